// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined, single-ported memory between I-cache
// block fills, D-cache block fills and D-cache write-through stores.
// A block fill is issued as WORDS_PER_BLOCK back-to-back 16-bit reads.
// Returned words are steered to the owning cache's fill port. Completion is
// reported with a one-cycle done pulse.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   icache_req/addr          I-cache miss request and byte address
//   dcache_req/wr/addr/wdata D-cache request (wr=1 store, wr=0 block fill)
//   mem_en/wr/addr/wdata     memory command
//   mem_rdata/mem_valid      in-order, fixed-latency read return
//   fill_addr/fill_data      word being written into a cache
//   icache_fill_we/dcache_fill_we  per-cache fill write enables
//   icache_stall/dcache_stall      hold the requesting pipeline stage
//   icache_done/dcache_done        one-cycle completion pulses
module mem_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [15:0]       dcache_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              icache_fill_we,
  output logic              dcache_fill_we,
  output logic              icache_stall,
  output logic              dcache_stall,
  output logic              icache_done,
  output logic              dcache_done
);

  localparam int unsigned       CNT_W    = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic              last_grant;
  // issue_cnt wraps after the last word, so a separate flag marks that
  // read commands are still being issued for the current block.
  logic              issuing;

  logic grant_d, grant_i;
  logic fill_active, ret_hit, last_ret;

  // Alternate on contention: the requester not served last time wins.
  assign grant_d = dcache_req & (~icache_req | ~last_grant);
  assign grant_i = icache_req & ~grant_d;

  assign fill_active = (state == I_FILL) || (state == D_FILL);
  assign ret_hit     = fill_active & mem_valid;
  assign last_ret    = ret_hit & (ret_cnt == LAST);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      next_state = dcache_wr ? D_WRITE : D_FILL;
        else if (grant_i) next_state = I_FILL;
      end
      I_FILL, D_FILL: if (last_ret) next_state = IDLE;
      D_WRITE:        next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_en         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    fill_addr      = '0;
    fill_data      = '0;
    icache_fill_we = 1'b0;
    dcache_fill_we = 1'b0;
    icache_done    = 1'b0;
    dcache_done    = 1'b0;
    if (state == D_WRITE) begin
      mem_en      = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = dcache_addr;
      mem_wdata   = dcache_wdata;
      dcache_done = 1'b1;
    end
    if (fill_active && issuing) begin
      mem_en   = 1'b1;
      mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
    end
    if (ret_hit) begin
      fill_addr      = base + ADDR_W'({ret_cnt, 1'b0});
      fill_data      = mem_rdata;
      icache_fill_we = (state == I_FILL);
      dcache_fill_we = (state == D_FILL);
      icache_done    = last_ret & (state == I_FILL);
      dcache_done    = last_ret & (state == D_FILL);
    end
  end

  assign icache_stall = icache_req & ~icache_done;
  assign dcache_stall = dcache_req & ~dcache_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      last_grant <= 1'b0;
      issuing    <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            base       <= (grant_d ? dcache_addr : icache_addr) & BLK_MASK;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            last_grant <= grant_d;
            issuing    <= ~(grant_d & dcache_wr);
          end
        end
        I_FILL, D_FILL: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == LAST) issuing <= 1'b0;
          end
          if (ret_hit) ret_cnt <= ret_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
